// File: rtl/sc_timing_monitor_if.sv
// Bus between the timing monitor and the harness that drives the composed cores.
// The master drives start/mode/finish levels and the slave (monitor) returns the results.
interface sc_timing_monitor_if #(
    parameter int unsigned NCOPY = 2,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             mode;
    logic [NCOPY-1:0] finish_vec;
    logic             busy;
    logic             done;
    logic             leak;
    logic             timeout;
    logic [NCOPY-1:0] leak_mask;
    logic [CNT_W-1:0] first_leak_cycle;
    logic [CNT_W-1:0] lat_min;
    logic [CNT_W-1:0] lat_max;

    modport master (
        output start, mode, finish_vec,
        input  busy, done, leak, timeout, leak_mask, first_leak_cycle, lat_min, lat_max
    );

    modport slave (
        input  start, mode, finish_vec,
        output busy, done, leak, timeout, leak_mask, first_leak_cycle, lat_min, lat_max
    );
endinterface

// File: rtl/sc_timing_monitor.sv
// Timing-equivalence monitor for NCOPY self-composed crypto cores: measures per-copy latency
// and flags any secret-dependent divergence from reference copy 0.
module sc_timing_monitor #(
    parameter int unsigned NCOPY   = 2,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned TOL     = 0
) (
    input logic                clk,
    input logic                rst_n,
    sc_timing_monitor_if.slave mon_io
);
    localparam logic [CNT_W-1:0] TimeoutC    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TolC        = CNT_W'(TOL);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cyc_q, cyc_d;
    logic [NCOPY-1:0]             seen_q, seen_d;
    logic [NCOPY-1:0][CNT_W-1:0]  lat_q, lat_d;
    logic                         mode_q, mode_d;
    logic                         leak_q, leak_d;
    logic                         timeout_q, timeout_d;
    logic [NCOPY-1:0]             mask_q, mask_d;
    logic [CNT_W-1:0]             first_q, first_d;
    logic [CNT_W-1:0]             min_q, min_d;
    logic [CNT_W-1:0]             max_q, max_d;

    logic [NCOPY-1:0] arrived, diff, mask_end;
    logic             all_arr;
    logic [CNT_W-1:0] lo, hi, dlt;

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        seen_d    = seen_q;
        lat_d     = lat_q;
        mode_d    = mode_q;
        leak_d    = leak_q;
        timeout_d = timeout_q;
        mask_d    = mask_q;
        first_d   = first_q;
        min_d     = min_q;
        max_d     = max_q;
        mask_end  = '0;
        lo        = '0;
        hi        = '0;
        dlt       = '0;

        arrived = seen_q | mon_io.finish_vec;
        diff    = arrived ^ {NCOPY{arrived[0]}};
        all_arr = &arrived;

        case (state_q)
            StIdle: begin
                if (mon_io.start) begin
                    state_d   = StRun;
                    cyc_d     = '0;
                    seen_d    = '0;
                    mode_d    = mon_io.mode;
                    leak_d    = 1'b0;
                    timeout_d = 1'b0;
                    mask_d    = '0;
                    first_d   = '0;
                end
            end
            StRun: begin
                cyc_d = cyc_q + 1'b1;
                for (int i = 0; i < NCOPY; i++) begin
                    if (mon_io.finish_vec[i] && !seen_q[i]) begin
                        seen_d[i] = 1'b1;
                        lat_d[i]  = cyc_q;
                    end
                end
                // Lockstep: leak_q doubles as "divergence already recorded"
                if (!mode_q && (|diff)) begin
                    leak_d = 1'b1;
                    mask_d = mask_q | diff;
                    if (!leak_q) first_d = cyc_q;
                end
                if (all_arr || (cyc_q == TimeoutLast)) begin
                    state_d   = StDone;
                    timeout_d = !all_arr;
                    for (int i = 0; i < NCOPY; i++) begin
                        if (!arrived[i]) lat_d[i] = TimeoutC;
                    end
                    lo = lat_d[0];
                    hi = lat_d[0];
                    for (int i = 1; i < NCOPY; i++) begin
                        if (lat_d[i] < lo) lo = lat_d[i];
                        if (lat_d[i] > hi) hi = lat_d[i];
                    end
                    min_d    = lo;
                    max_d    = hi;
                    mask_end = diff;
                    if (mode_q) begin
                        for (int i = 1; i < NCOPY; i++) begin
                            dlt = (lat_d[i] > lat_d[0]) ? lat_d[i] - lat_d[0]
                                                        : lat_d[0] - lat_d[i];
                            if (dlt > TolC) mask_end[i] = 1'b1;
                        end
                    end
                    mask_d = mask_d | mask_end;
                    if ((|mask_end) || (mode_q && ((hi - lo) > TolC))) leak_d = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cyc_q     <= '0;
            seen_q    <= '0;
            lat_q     <= '0;
            mode_q    <= 1'b0;
            leak_q    <= 1'b0;
            timeout_q <= 1'b0;
            mask_q    <= '0;
            first_q   <= '0;
            min_q     <= '0;
            max_q     <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            seen_q    <= seen_d;
            lat_q     <= lat_d;
            mode_q    <= mode_d;
            leak_q    <= leak_d;
            timeout_q <= timeout_d;
            mask_q    <= mask_d;
            first_q   <= first_d;
            min_q     <= min_d;
            max_q     <= max_d;
        end
    end

    assign mon_io.busy             = (state_q == StRun);
    assign mon_io.done             = (state_q == StDone);
    assign mon_io.leak             = leak_q;
    assign mon_io.timeout          = timeout_q;
    assign mon_io.leak_mask        = mask_q;
    assign mon_io.first_leak_cycle = first_q;
    assign mon_io.lat_min          = min_q;
    assign mon_io.lat_max          = max_q;
endmodule

// File: tb/tb_sc_timing_monitor.sv
// Directed bench for sc_timing_monitor: a 2-copy instance (TIMEOUT=64, TOL=4) and a 4-copy one.
module tb_sc_timing_monitor;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    sc_timing_monitor_if #(.NCOPY(2), .CNT_W(16)) if2 ();
    sc_timing_monitor_if #(.NCOPY(4), .CNT_W(16)) if4 ();

    sc_timing_monitor #(.NCOPY(2), .CNT_W(16), .TIMEOUT(64), .TOL(4)) dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .mon_io (if2)
    );

    sc_timing_monitor #(.NCOPY(4), .CNT_W(16), .TIMEOUT(4096), .TOL(0)) dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .mon_io (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          done_at;
    logic        o_leak, o_tmo;
    logic [3:0]  o_mask;
    logic [15:0] o_first, o_min, o_max;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a run, drive finish levels per cycle, stop at the done pulse (cycle budget 200).
    // aN < 0 means copy N never finishes; pulse3 makes copy 3 finish for one cycle only.
    task automatic run(input bit sel, input bit m, input int a0, input int a1, input int a2,
                       input int a3, input bit pulse3, input int ign_at, output int dat);
        logic [3:0] fv;
        @(negedge clk);
        if (sel) begin
            if4.start = 1'b1;
            if4.mode  = m;
        end else begin
            if2.start = 1'b1;
            if2.mode  = m;
        end
        @(negedge clk);
        if2.start = 1'b0;
        if4.start = 1'b0;
        dat = -1;
        for (int c = 0; c < 200; c++) begin
            fv[0] = (a0 >= 0) && (c >= a0);
            fv[1] = (a1 >= 0) && (c >= a1);
            fv[2] = (a2 >= 0) && (c >= a2);
            fv[3] = pulse3 ? (c == a3) : ((a3 >= 0) && (c >= a3));
            if (sel) begin
                if4.finish_vec = fv;
                if4.start      = (c == ign_at);
            end else begin
                if2.finish_vec = fv[1:0];
            end
            @(negedge clk);
            if (sel ? if4.done : if2.done) begin
                dat = c + 1;
                break;
            end
        end
        if (sel) begin
            o_leak = if4.leak; o_tmo = if4.timeout; o_mask = if4.leak_mask;
            o_first = if4.first_leak_cycle; o_min = if4.lat_min; o_max = if4.lat_max;
        end else begin
            o_leak = if2.leak; o_tmo = if2.timeout; o_mask = {2'b00, if2.leak_mask};
            o_first = if2.first_leak_cycle; o_min = if2.lat_min; o_max = if2.lat_max;
        end
        if2.finish_vec = '0;
        if4.finish_vec = '0;
        if4.start      = 1'b0;
    endtask

    task automatic check_res(input string tag, input int edone, input logic eleak,
                             input logic etmo, input logic [3:0] emask, input int efirst,
                             input int emin, input int emax);
        chk({tag, ".done_at"}, 64'(done_at), 64'(edone));
        chk({tag, ".leak"},    64'(o_leak),  64'(eleak));
        chk({tag, ".timeout"}, 64'(o_tmo),   64'(etmo));
        chk({tag, ".mask"},    64'(o_mask),  64'(emask));
        chk({tag, ".first"},   64'(o_first), 64'(efirst));
        chk({tag, ".lat_min"}, 64'(o_min),   64'(emin));
        chk({tag, ".lat_max"}, 64'(o_max),   64'(emax));
    endtask

    function automatic logic [63:0] outs2();
        return {10'b0, if2.busy, if2.done, if2.leak, if2.timeout, if2.leak_mask,
                if2.first_leak_cycle, if2.lat_min, if2.lat_max};
    endfunction

    function automatic logic [63:0] outs4();
        return {8'b0, if4.busy, if4.done, if4.leak, if4.timeout, if4.leak_mask,
                if4.first_leak_cycle, if4.lat_min, if4.lat_max};
    endfunction

    initial begin
        rst_n = 1'b0;
        if2.start = 1'b0; if2.mode = 1'b0; if2.finish_vec = '0;
        if4.start = 1'b0; if4.mode = 1'b0; if4.finish_vec = '0;
        repeat (3) @(negedge clk);
        chk("reset.dut2", outs2(), 64'd0);
        chk("reset.dut4", outs4(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1 lockstep, matched arrivals
        run(1'b0, 1'b0, 37, 37, -1, -1, 1'b0, -1, done_at);
        check_res("t1", 38, 1'b0, 1'b0, 4'b0000, 0, 37, 37);
        @(negedge clk);
        chk("t1.done_pulse", 64'(if2.done), 64'd0);
        chk("t1.busy_idle",  64'(if2.busy), 64'd0);

        // T2 lockstep divergence
        run(1'b0, 1'b0, 37, 41, -1, -1, 1'b0, -1, done_at);
        check_res("t2", 42, 1'b1, 1'b0, 4'b0010, 37, 37, 41);

        // T3 tolerant: spread 4 within TOL, spread 5 beyond
        run(1'b0, 1'b1, 37, 41, -1, -1, 1'b0, -1, done_at);
        check_res("t3a", 42, 1'b0, 1'b0, 4'b0000, 0, 37, 41);
        run(1'b0, 1'b1, 37, 42, -1, -1, 1'b0, -1, done_at);
        check_res("t3b", 43, 1'b1, 1'b0, 4'b0010, 0, 37, 42);

        // T4 timeout: copy 1 never finishes
        run(1'b0, 1'b0, 10, -1, -1, -1, 1'b0, -1, done_at);
        check_res("t4", 64, 1'b1, 1'b1, 4'b0010, 10, 10, 64);

        // Arrival on the last RUN cycle wins over timeout
        run(1'b0, 1'b0, 63, 63, -1, -1, 1'b0, -1, done_at);
        check_res("t4edge", 64, 1'b0, 1'b0, 4'b0000, 0, 63, 63);

        // Tolerant mode with a missing copy still leaks via arrival mismatch
        run(1'b0, 1'b1, 62, -1, -1, -1, 1'b0, -1, done_at);
        check_res("t4tol", 64, 1'b1, 1'b1, 4'b0010, 0, 62, 64);

        // T5 four copies, copy 3 finish pulsed for one cycle
        run(1'b1, 1'b0, 20, 20, 20, 20, 1'b1, -1, done_at);
        check_res("t5a", 21, 1'b0, 1'b0, 4'b0000, 0, 20, 20);
        // Second run with a stray start pulse at RUN cycle 10
        run(1'b1, 1'b0, 30, 30, 30, 30, 1'b0, 10, done_at);
        check_res("t5b", 31, 1'b0, 1'b0, 4'b0000, 0, 30, 30);

        // T6 reset mid-run
        @(negedge clk);
        if2.start = 1'b1;
        if2.mode  = 1'b0;
        @(negedge clk);
        if2.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6.busy_before", 64'(if2.busy), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6.outs_in_reset", outs2(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t6.no_done", 64'(if2.done), 64'd0);
        end
        run(1'b0, 1'b0, 37, 37, -1, -1, 1'b0, -1, done_at);
        check_res("t6", 38, 1'b0, 1'b0, 4'b0000, 0, 37, 37);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
